// File: rtl/abc_debounce_pkg.sv
// Shared types and constants for the three-channel input debouncer.
package abc_debounce_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_t;

    localparam int unsigned NUM_CH = 3;

    localparam int unsigned CH_A = 0;
    localparam int unsigned CH_B = 1;
    localparam int unsigned CH_C = 2;

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: synchroniser chain, STABLE/PENDING FSM and the
// consecutive-mismatch counter that qualifies an output flip.
module debounce_chan
    import abc_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_i,
    output logic       out_o,
    output logic       changed_o,
    output deb_state_t state_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_chan: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
        $error("debounce_chan: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    deb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   changed_q, changed_d;
    logic                   mismatch;
    logic                   last;

    // Shift the raw line through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign mismatch = (s != out_q);
    assign last     = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    // State register plus the registered counter, output and change strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= STABLE;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            changed_q <= changed_d;
        end
    end

    // Next-state: leave STABLE on a mismatch, return on a glitch or a flip.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STABLE:  if (mismatch) state_d = PENDING;
            PENDING: if (!mismatch || last) state_d = STABLE;
            default: state_d = STABLE;
        endcase
    end

    // Counter, output and strobe updates for the current state.
    always_comb begin
        cnt_d     = '0;
        out_d     = out_q;
        changed_d = 1'b0;
        case (state_q)
            STABLE: begin
                if (mismatch) cnt_d = CNT_W'(1);
            end
            PENDING: begin
                if (mismatch) begin
                    if (last) begin
                        out_d     = s;
                        changed_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign out_o     = out_q;
    assign changed_o = changed_q;
    assign state_o   = state_q;

endmodule

// File: rtl/abc_input_debouncer.sv
// Conditions the three raw A/B/C lines for the AND/OR gate block: one
// debounce_chan per line, change strobes packed {C,B,A}, all-settled flag.
module abc_input_debouncer
    import abc_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_raw,
    input  logic       b_raw,
    input  logic       c_raw,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic [2:0] changed,
    output logic       settled
);

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] out_vec;
    logic [NUM_CH-1:0] chg_vec;
    deb_state_t        st [NUM_CH];

    assign raw_vec = {c_raw, b_raw, a_raw};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .raw_i     (raw_vec[i]),
            .out_o     (out_vec[i]),
            .changed_o (chg_vec[i]),
            .state_o   (st[i])
        );
    end

    assign A       = out_vec[CH_A];
    assign B       = out_vec[CH_B];
    assign C       = out_vec[CH_C];
    assign changed = chg_vec;

    // Settled straight from the state registers, no extra pipeline stage.
    assign settled = (st[CH_A] == STABLE) && (st[CH_B] == STABLE) && (st[CH_C] == STABLE);

endmodule
